// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave). One outstanding request at a time.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage with IF/ID pipeline register, a one-entry
// decode-stall buffer and redirect handling for in-flight memory requests.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_stage_if.master        imem,
    input  logic                 stall_d,
    input  logic                 pcsrc_e,
    input  logic [31:0]          pctarget_e,
    output logic [31:0]          instr_d,
    output logic [31:0]          pc_d,
    output logic [31:0]          pcplus4_d,
    output logic                 valid_d
);

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & PC_ALIGN_MASK;

    // BUF: word fetched during a decode stall is parked, no request issued.
    // KILL: redirect arrived mid-request; the stale response must be drained.
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_BUF   = 2'd1,
        S_KILL  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc_f;
    logic [31:0] r_buf_instr;
    logic [31:0] r_saved_target;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pcplus4_d;
    logic        r_valid_d;

    state_t      w_state_next;
    logic [31:0] w_pc_f_next;
    logic [31:0] w_buf_instr_next;
    logic [31:0] w_saved_target_next;
    logic [31:0] w_instr_d_next;
    logic [31:0] w_pc_d_next;
    logic [31:0] w_pcplus4_d_next;
    logic        w_valid_d_next;

    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic        w_rvalid;

    assign w_target   = pctarget_e & PC_ALIGN_MASK;
    assign w_pc_plus4 = r_pc_f + 32'd4;
    assign w_rvalid   = imem.imem_rvalid;

    assign imem.imem_req  = !reset && (r_state != S_BUF);
    assign imem.imem_addr = r_pc_f;

    assign instr_d   = r_instr_d;
    assign pc_d      = r_pc_d;
    assign pcplus4_d = r_pcplus4_d;
    assign valid_d   = r_valid_d;

    always_comb begin
        w_state_next        = r_state;
        w_pc_f_next         = r_pc_f;
        w_buf_instr_next    = r_buf_instr;
        w_saved_target_next = r_saved_target;
        w_instr_d_next      = r_instr_d;
        w_pc_d_next         = r_pc_d;
        w_pcplus4_d_next    = r_pcplus4_d;
        w_valid_d_next      = r_valid_d;

        case (r_state)
            S_FETCH: begin
                if (w_rvalid) begin
                    if (pcsrc_e) begin
                        w_pc_f_next    = w_target;
                        w_instr_d_next = NOP_INSTR;
                        w_valid_d_next = 1'b0;
                    end else if (!stall_d) begin
                        w_instr_d_next   = imem.imem_rdata;
                        w_pc_d_next      = r_pc_f;
                        w_pcplus4_d_next = w_pc_plus4;
                        w_valid_d_next   = 1'b1;
                        w_pc_f_next      = w_pc_plus4;
                    end else begin
                        w_buf_instr_next = imem.imem_rdata;
                        w_state_next     = S_BUF;
                    end
                end else begin
                    if (pcsrc_e) begin
                        w_saved_target_next = w_target;
                        w_instr_d_next      = NOP_INSTR;
                        w_valid_d_next      = 1'b0;
                        w_state_next        = S_KILL;
                    end else if (!stall_d) begin
                        w_instr_d_next = NOP_INSTR;
                        w_valid_d_next = 1'b0;
                    end
                end
            end

            S_BUF: begin
                if (pcsrc_e) begin
                    w_pc_f_next    = w_target;
                    w_instr_d_next = NOP_INSTR;
                    w_valid_d_next = 1'b0;
                    w_state_next   = S_FETCH;
                end else if (!stall_d) begin
                    // pc_f was not advanced when the word was parked, so it still names it.
                    w_instr_d_next   = r_buf_instr;
                    w_pc_d_next      = r_pc_f;
                    w_pcplus4_d_next = w_pc_plus4;
                    w_valid_d_next   = 1'b1;
                    w_pc_f_next      = w_pc_plus4;
                    w_state_next     = S_FETCH;
                end
            end

            S_KILL: begin
                if (pcsrc_e) begin
                    w_saved_target_next = w_target;
                end
                if (w_rvalid) begin
                    w_pc_f_next  = pcsrc_e ? w_target : r_saved_target;
                    w_state_next = S_FETCH;
                end
                if (pcsrc_e || !stall_d) begin
                    w_instr_d_next = NOP_INSTR;
                    w_valid_d_next = 1'b0;
                end
            end

            default: begin
                w_state_next = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_FETCH;
            r_pc_f         <= RESET_PC_ALIGNED;
            r_buf_instr    <= 32'd0;
            r_saved_target <= 32'd0;
            r_instr_d      <= NOP_INSTR;
            r_pc_d         <= 32'd0;
            r_pcplus4_d    <= 32'd0;
            r_valid_d      <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_pc_f         <= w_pc_f_next;
            r_buf_instr    <= w_buf_instr_next;
            r_saved_target <= w_saved_target_next;
            r_instr_d      <= w_instr_d_next;
            r_pc_d         <= w_pc_d_next;
            r_pcplus4_d    <= w_pcplus4_d_next;
            r_valid_d      <= w_valid_d_next;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// stall/redirect/wait-state traffic checked against a queue-based reference.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_d;
    logic        pcsrc_e;
    logic [31:0] pctarget_e;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem       (bus),
        .stall_d    (stall_d),
        .pcsrc_e    (pcsrc_e),
        .pctarget_e (pctarget_e),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pcplus4_d  (pcplus4_d),
        .valid_d    (valid_d)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Memory contents: odd multiplier keeps every address's word distinct.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // Reference: pending work is a 0/1-entry queue plus a "drain stale response" flag.
    logic [31:0] m_pc_f;
    logic [31:0] m_buf[$];
    bit          m_kill;
    logic [31:0] m_target;
    logic [31:0] m_instr, m_pc_d, m_pc4;
    logic        m_valid;

    bit          mem_busy;
    int          mem_cnt;
    int          wait_min = 0;
    int          wait_max = 0;

    bit          sb_have_last;
    bit          sb_redirect;
    logic [31:0] sb_last_pc;

    task automatic m_bubble();
        m_instr = NOP;
        m_valid = 1'b0;
    endtask

    task automatic m_deliver(input logic [31:0] w);
        m_instr = w;
        m_pc_d  = m_pc_f;
        m_pc4   = m_pc_f + 32'd4;
        m_valid = 1'b1;
        m_pc_f  = m_pc_f + 32'd4;
    endtask

    // One clock cycle: drive inputs at negedge, predict, then check at next negedge.
    task automatic step(input bit rst, input bit stall, input bit br, input logic [31:0] tgt);
        bit          req, rv;
        logic [31:0] rdata, t;
        req = !rst && (m_buf.size() == 0);
        if (req) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_cnt  = $urandom_range(wait_max, wait_min);
            end
            rv = (mem_cnt == 0);
            if (rv) mem_busy = 1'b0;
            else    mem_cnt--;
            rdata = mem_word(m_pc_f);
        end else begin
            mem_busy = 1'b0;
            rv       = 1'($urandom_range(1, 0));
            rdata    = $urandom;
        end
        reset           = rst;
        stall_d         = stall;
        pcsrc_e         = br;
        pctarget_e      = tgt;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rdata;
        #1;
        check_eq("imem_req", {31'd0, bus.imem_req}, {31'd0, req});
        if (req) check_eq("imem_addr", bus.imem_addr, m_pc_f);

        t = tgt & 32'hFFFF_FFFC;
        if (rst) begin
            m_pc_f = 32'd0; m_buf.delete(); m_kill = 1'b0; m_target = 32'd0;
            m_instr = NOP; m_pc_d = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
            sb_have_last = 1'b0;
        end else if (m_buf.size() != 0) begin
            if (br) begin
                m_buf.delete(); m_pc_f = t; m_bubble();
            end else if (!stall) begin
                m_deliver(m_buf.pop_front());
            end
        end else if (m_kill) begin
            if (br) m_target = t;
            if (rv) begin
                m_pc_f = m_target; m_kill = 1'b0;
            end
            if (br || !stall) m_bubble();
        end else if (rv) begin
            if (br)          begin m_pc_f = t; m_bubble(); end
            else if (!stall) m_deliver(rdata);
            else             m_buf.push_back(rdata);
        end else begin
            if (br)          begin m_target = t; m_kill = 1'b1; m_bubble(); end
            else if (!stall) m_bubble();
        end
        if (br || rst) sb_redirect = 1'b1;

        @(posedge clk);
        @(negedge clk);
        check_eq("instr_d",   instr_d,   m_instr);
        check_eq("pc_d",      pc_d,      m_pc_d);
        check_eq("pcplus4_d", pcplus4_d, m_pc4);
        check_eq("valid_d",   {31'd0, valid_d}, {31'd0, m_valid});
        if (valid_d && !stall && !rst) begin
            check_eq("ifid_word", instr_d, mem_word(pc_d));
            check_eq("pc4_rel", pcplus4_d, pc_d + 32'd4);
            if (sb_have_last && !sb_redirect) check_eq("pc_seq", pc_d, sb_last_pc + 32'd4);
            sb_last_pc   = pc_d;
            sb_have_last = 1'b1;
            sb_redirect  = 1'b0;
            $display("txn pc=%08h instr=%08h", pc_d, instr_d);
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcount;
        int seen;
        bit found;
        reset = 1'b1; stall_d = 1'b0; pcsrc_e = 1'b0; pctarget_e = 32'd0;
        bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'd0;
        m_buf.delete();
        @(negedge clk);

        // Reset state and zero-wait streaming.
        wait_min = 0; wait_max = 0;
        do_reset(); do_reset();
        check_eq("rst_instr", instr_d, NOP);
        check_eq("rst_pc_d", pc_d, 32'd0);
        check_eq("rst_valid", {31'd0, valid_d}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'd0);
            check_eq("seq_pc_d", pc_d, 32'(i * 4));
            check_eq("seq_valid", {31'd0, valid_d}, 32'd1);
            check_eq("seq_instr", instr_d, mem_word(32'(i * 4)));
        end

        // Two wait cycles: one delivery every third cycle.
        wait_min = 2; wait_max = 2;
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'd0);
            if (valid_d) vcount++;
        end
        check_eq("wait2_rate", 32'(vcount), 32'd4);

        // Decode stall across a response parks the word; release delivers it once.
        do_reset();
        wait_min = 1; wait_max = 1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'd0);
        check_eq("buf_req_low", {31'd0, bus.imem_req}, 32'd0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'd0);

        // Redirect while the fetch at 0x20 is outstanding with 3 wait cycles.
        do_reset();
        wait_min = 0; wait_max = 0;
        step(1'b0, 1'b0, 1'b1, 32'h0000_0020);
        wait_min = 3; wait_max = 3;
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0102);
        seen = 0; found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'd0);
            if (valid_d) seen++;
            if (bus.imem_req && bus.imem_addr == 32'h0000_0100) found = 1'b1;
        end
        check_eq("kill_no_valid", 32'(seen), 32'd0);
        check_eq("kill_next_addr", {31'd0, found}, 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'd0);
            if (valid_d && pc_d == 32'h0000_0020) seen++;
        end
        check_eq("kill_0x20_never", 32'(seen), 32'd0);

        // Redirect while parked in BUF under stall.
        do_reset();
        wait_min = 0; wait_max = 0;
        step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0040);
        check_eq("bufkill_valid", {31'd0, valid_d}, 32'd0);
        check_eq("bufkill_addr", bus.imem_addr, 32'h0000_0040);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check_eq("bufkill_first", pc_d, 32'h0000_0040);

        // Reset during a wait cycle, then PC wrap.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
        wait_min = 2; wait_max = 2;
        step(1'b0, 1'b0, 1'b0, 32'd0);
        do_reset();
        check_eq("mrst_instr", instr_d, NOP);
        check_eq("mrst_pc_d", pc_d, 32'd0);
        check_eq("mrst_pc4", pcplus4_d, 32'd0);
        check_eq("mrst_valid", {31'd0, valid_d}, 32'd0);
        reset = 1'b0;
        #1;
        check_eq("mrst_req", {31'd0, bus.imem_req}, 32'd1);
        check_eq("mrst_addr", bus.imem_addr, 32'd0);
        wait_min = 0; wait_max = 0;
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check_eq("wrap_pc_d", pc_d, 32'hFFFF_FFFC);
        check_eq("wrap_pc4", pcplus4_d, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check_eq("wrap_next", pc_d, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            bit rst, stall, br;
            logic [31:0] tgt;
            if (i % 200 == 0) begin
                wait_min = 0;
                wait_max = $urandom_range(3, 0);
            end
            rst   = ($urandom_range(99, 0) < 1);
            stall = ($urandom_range(99, 0) < 30);
            br    = ($urandom_range(99, 0) < 8);
            tgt   = $urandom & 32'h0000_3FFF;
            step(rst, stall, br, tgt);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and IF/ID pipeline register for the RV32I core. Holds the fetch PC and issues one outstanding request at a time to instruction memory, which may stall for any number of cycles. Presents each fetched word with its PC to the decode stage, where instr_d[31:7] feeds the immediate extender. Handles decode stalls with a one-entry buffer and taken branch/jump redirects from execute, including redirects that arrive while a memory request is still outstanding.

## Interface
- RESET_PC, 32'h0000_0000: fetch address after reset; bits [1:0] must be 00.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held high with imem_addr stable until imem_rvalid.
- imem_addr  out  32  fetch address; always equals pc_f.
- imem_rvalid  in  1  response valid; may rise in the same cycle as imem_req (zero-wait); meaningful only while imem_req=1.
- imem_rdata  in  32  instruction word; valid while imem_rvalid=1.
- stall_d  in  1  hazard unit: hold the IF/ID register.
- pcsrc_e  in  1  taken branch/jump in execute; redirect fetch.
- pctarget_e  in  32  redirect target (PC + immext, or jalr result).
- instr_d  out  32  IF/ID instruction (registered).
- pc_d  out  32  IF/ID PC (registered).
- pcplus4_d  out  32  IF/ID PC+4 (registered).
- valid_d  out  1  IF/ID holds a real instruction (registered).

## Operation
- State: pc_f (32), a 1-entry buffer (buf_instr), saved_target (32), and FSM states FETCH, BUF, KILL.
- imem_req = 0 while reset=1. Otherwise imem_req = 1 in FETCH and KILL, and 0 in BUF.
- Any target loaded into pc_f has bits [1:0] forced to 00.
- A bubble writes instr_d=32'h0000_0013 (NOP), valid_d=0 and leaves pc_d and pcplus4_d unchanged.
- FETCH, imem_rvalid=1:
  - If pcsrc_e=1: discard the word, pc_f<=pctarget_e, bubble; stay in FETCH.
  - Else if stall_d=0: IF/ID<={imem_rdata, pc_f, pc_f+4}, valid_d<=1, pc_f<=pc_f+4.
  - Else (stall_d=1): buf_instr<=imem_rdata, IF/ID held, go to BUF.
- FETCH, imem_rvalid=0:
  - If pcsrc_e=1: saved_target<=pctarget_e, bubble, go to KILL.
  - Else if stall_d=0: bubble.
  - Else: IF/ID held.
- BUF:
  - If pcsrc_e=1: drop the buffer, pc_f<=pctarget_e, bubble, go to FETCH.
  - Else if stall_d=0: IF/ID<={buf_instr, pc_f, pc_f+4}, valid_d<=1, pc_f<=pc_f+4, go to FETCH.
  - Else: hold.
- KILL: imem_addr keeps the old pc_f until the response.
  - pcsrc_e=1 overwrites saved_target.
  - On imem_rvalid: discard the word, pc_f<=(pcsrc_e ? pctarget_e : saved_target), go to FETCH.
  - IF/ID: bubble unless stall_d=1 and pcsrc_e=0, in which case it is held.
- Priority: pcsrc_e (flush) over stall_d. A flush always clears valid_d, even while stalled.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values: pc_f=RESET_PC, state=FETCH, instr_d=32'h0000_0013, pc_d=0, pcplus4_d=0, valid_d=0, buf_instr=0, saved_target=0.
- imem_req first rises in the first cycle with reset=0.
- Reset asserted mid-operation: all state and outputs return to reset values at the next edge. Any outstanding response is ignored, because imem_req=0 during reset.
- Zero-wait memory, no stalls: one instruction per cycle. The word fetched in cycle N appears on instr_d in cycle N+1.
- With N wait cycles per fetch: one instruction every N+1 cycles, with bubbles in between.
- Redirect to first new instruction valid in decode:
  - FETCH with a response present, or BUF: 2 cycles with zero-wait memory.
  - KILL: remaining wait cycles plus 2.
- No instruction is ever lost or duplicated across a stall.

## Test plan
- Reset, zero-wait memory returning addr-based words, no stalls. Required: pc_d sequence 0,4,8,12 on consecutive cycles; valid_d=1 from cycle 2; instr_d matches memory.
- Memory with 2 wait cycles. Required: imem_addr stable for 3 cycles per fetch; valid_d pattern 1,0,0 repeating; pcplus4_d=pc_d+4.
- stall_d=1 for 3 cycles while a response arrives. Required: FSM enters BUF, imem_req=0, IF/ID frozen; after release, the buffered word appears once with the correct pc_d and no gap in pc_d.
- pcsrc_e=1 with pctarget_e=32'h0000_0102 while a fetch at 0x20 is outstanding (3 wait cycles). Required: the 0x20 word is never valid in decode; the next request is at 0x100; valid_d=0 until 0x100 arrives.
- Redirect while in BUF with stall_d=1. Required: the buffered word is dropped, valid_d=0, next imem_addr = target.
- Reset asserted during a wait cycle, plus a PC wrap from 32'hFFFF_FFFC. Required: outputs return to reset values, the next request is at RESET_PC, and pcplus4_d wraps to 0.
